// File: rtl/fish_spawn_ctrl.sv
// Fish slot spawn scheduler: per-slot IDLE/ACTIVE/COOLDOWN FSMs, gap timer with pending spawn, catch counter.
// Optional FISH_SPAWN_RANDOM_EN: way/movetype come from a 16-bit Galois LFSR instead of the spawn count.
module fish_spawn_ctrl #(
  parameter int unsigned NUM_FISH       = 4,
  parameter int unsigned SPAWN_GAP      = 6,
  parameter int unsigned COOLDOWN_TICKS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    game_en,
  input  logic                    tick,
  input  logic [NUM_FISH-1:0]     caught,
  input  logic [NUM_FISH-1:0]     offscreen,
  output logic [NUM_FISH-1:0]     appear,
  output logic [2*NUM_FISH-1:0]   way,
  output logic [3*NUM_FISH-1:0]   movetype,
  output logic                    spawn_pulse,
  output logic [7:0]              catch_cnt
);

  localparam int unsigned TW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int unsigned CW = $clog2(COOLDOWN_TICKS + 1);
  localparam int unsigned IW = (NUM_FISH > 1) ? $clog2(NUM_FISH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_COOLDOWN
  } slot_state_t;

  slot_state_t     state_q [NUM_FISH];
  slot_state_t     state_d [NUM_FISH];
  logic [CW-1:0]   cd_q    [NUM_FISH];
  logic [CW-1:0]   cd_d    [NUM_FISH];

  logic [TW-1:0]   timer_q, timer_d;
  logic            pending_q, pending_d;
  logic [15:0]     spawn_cnt_q;
  logic [7:0]      catch_d;
  logic [8:0]      catch_sum;
  logic            any_idle;
  logic [IW-1:0]   spawn_idx;
  logic            timer_at_end;
  logic            do_spawn;
  logic [1:0]      new_way;
  logic [2:0]      new_mt;

`ifdef FISH_SPAWN_RANDOM_EN
  logic [15:0]     lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_comb begin
    new_way = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];
    new_mt  = lfsr_q[4:2];
  end
`else
  always_comb begin
    new_way = 2'(spawn_cnt_q % 16'd3);
    new_mt  = spawn_cnt_q[2:0];
  end
`endif

  // Lowest-index IDLE slot, judged on registered state only
  always_comb begin
    any_idle  = 1'b0;
    spawn_idx = '0;
    for (int unsigned i = 0; i < NUM_FISH; i++) begin
      if (!any_idle && state_q[i] == S_IDLE) begin
        any_idle  = 1'b1;
        spawn_idx = IW'(i);
      end
    end
  end

  assign timer_at_end = (timer_q == TW'(SPAWN_GAP - 1));
  assign do_spawn     = game_en && any_idle && (pending_q || (tick && timer_at_end));

  always_comb begin
    timer_d   = timer_q;
    pending_d = pending_q;
    if (!game_en) begin
      timer_d   = '0;
      pending_d = 1'b0;
    end else if (do_spawn) begin
      timer_d   = '0;
      pending_d = 1'b0;
    end else if (tick && !pending_q) begin
      if (timer_at_end) begin
        pending_d = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_FISH; i++) begin
      state_d[i] = state_q[i];
      cd_d[i]    = cd_q[i];
      if (!game_en) begin
        state_d[i] = S_IDLE;
        cd_d[i]    = '0;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (do_spawn && spawn_idx == IW'(i)) state_d[i] = S_ACTIVE;
          end
          S_ACTIVE: begin
            if (caught[i] || offscreen[i]) begin
              state_d[i] = S_COOLDOWN;
              cd_d[i]    = CW'(COOLDOWN_TICKS);
            end
          end
          S_COOLDOWN: begin
            if (tick) begin
              if (cd_q[i] == CW'(1)) begin
                state_d[i] = S_IDLE;
                cd_d[i]    = '0;
              end else begin
                cd_d[i] = cd_q[i] - CW'(1);
              end
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            cd_d[i]    = '0;
          end
        endcase
      end
    end
  end

  // Several slots may be caught in one cycle; sum them before saturating
  always_comb begin
    catch_sum = {1'b0, catch_cnt};
    for (int unsigned i = 0; i < NUM_FISH; i++) begin
      if (game_en && state_q[i] == S_ACTIVE && caught[i]) catch_sum = catch_sum + 9'd1;
    end
    catch_d = catch_sum[8] ? 8'hFF : catch_sum[7:0];
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_FISH; i++) begin
      appear[i] = (state_q[i] == S_ACTIVE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_FISH; i++) begin
        state_q[i] <= S_IDLE;
        cd_q[i]    <= '0;
      end
      timer_q     <= '0;
      pending_q   <= 1'b0;
      spawn_cnt_q <= '0;
      catch_cnt   <= '0;
      spawn_pulse <= 1'b0;
      way         <= '0;
      movetype    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FISH; i++) begin
        state_q[i] <= state_d[i];
        cd_q[i]    <= cd_d[i];
        if (do_spawn && spawn_idx == IW'(i)) begin
          way[2*i +: 2]      <= new_way;
          movetype[3*i +: 3] <= new_mt;
        end
      end
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      spawn_pulse <= do_spawn;
      if (do_spawn) spawn_cnt_q <= spawn_cnt_q + 16'd1;
      catch_cnt   <= catch_d;
    end
  end

endmodule

// File: tb/tb_fish_spawn_ctrl.sv
// Self-checking bench for fish_spawn_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_fish_spawn_ctrl;

  localparam int NF  = 2;
  localparam int GAP = 4;
  localparam int CD  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            game_en;
  logic            tick;
  logic [NF-1:0]   caught;
  logic [NF-1:0]   offscreen;
  logic [NF-1:0]   appear;
  logic [2*NF-1:0] way;
  logic [3*NF-1:0] movetype;
  logic            spawn_pulse;
  logic [7:0]      catch_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fish_spawn_ctrl #(
    .NUM_FISH      (NF),
    .SPAWN_GAP     (GAP),
    .COOLDOWN_TICKS(CD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .game_en    (game_en),
    .tick       (tick),
    .caught     (caught),
    .offscreen  (offscreen),
    .appear     (appear),
    .way        (way),
    .movetype   (movetype),
    .spawn_pulse(spawn_pulse),
    .catch_cnt  (catch_cnt)
  );

  // Behavioural model: a fish is either alive, cooling (ticks left > 0) or free.
  bit          m_alive [NF];
  int          m_cool  [NF];
  int          m_way   [NF];
  int          m_mt    [NF];
  int          m_timer;
  bit          m_pend;
  int          m_spawns;
  int          m_catch;
  int          m_catch_total;
  bit          m_pulse;
  logic [15:0] m_lfsr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_alive[i] = 1'b0;
      m_cool[i]  = 0;
      m_way[i]   = 0;
      m_mt[i]    = 0;
    end
    m_timer  = 0;
    m_pend   = 1'b0;
    m_spawns = 0;
    m_catch  = 0;
    m_pulse  = 1'b0;
    m_lfsr   = 16'hACE1;
  endtask

  task automatic model_step();
    int          free_slot;
    bit          fire;
    logic [15:0] lfsr_pre;
    if (rst) begin
      model_reset();
      return;
    end
    lfsr_pre = m_lfsr;
    m_lfsr   = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    if (!game_en) begin
      for (int i = 0; i < NF; i++) begin
        m_alive[i] = 1'b0;
        m_cool[i]  = 0;
      end
      m_timer = 0;
      m_pend  = 1'b0;
      m_pulse = 1'b0;
      return;
    end
    free_slot = -1;
    for (int i = 0; i < NF; i++)
      if (free_slot < 0 && !m_alive[i] && m_cool[i] == 0) free_slot = i;
    fire = (free_slot >= 0) && (m_pend || (tick && m_timer == GAP - 1));
    for (int i = 0; i < NF; i++) begin
      if (m_alive[i] && (caught[i] || offscreen[i])) begin
        m_alive[i] = 1'b0;
        m_cool[i]  = CD;
        if (caught[i]) begin
          m_catch_total++;
          if (m_catch < 255) m_catch++;
        end
      end else if (m_cool[i] > 0 && tick) begin
        m_cool[i]--;
      end
    end
    if (fire) begin
      m_timer = 0;
      m_pend  = 1'b0;
    end else if (tick && !m_pend) begin
      if (m_timer == GAP - 1) m_pend = 1'b1;
      else                    m_timer++;
    end
    m_pulse = fire;
    if (fire) begin
      m_alive[free_slot] = 1'b1;
`ifdef FISH_SPAWN_RANDOM_EN
      m_way[free_slot] = (lfsr_pre[1:0] == 2'd3) ? 0 : int'(lfsr_pre[1:0]);
      m_mt[free_slot]  = int'(lfsr_pre[4:2]);
`else
      m_way[free_slot] = m_spawns % 3;
      m_mt[free_slot]  = m_spawns % 8;
`endif
      m_spawns = (m_spawns + 1) % 65536;
    end
  endtask

  task automatic compare_all();
    logic [NF-1:0]   ea;
    logic [2*NF-1:0] ew;
    logic [3*NF-1:0] em;
    for (int i = 0; i < NF; i++) begin
      ea[i]        = m_alive[i];
      ew[2*i +: 2] = 2'(m_way[i]);
      em[3*i +: 3] = 3'(m_mt[i]);
    end
    check_eq("appear", appear, ea);
    check_eq("way", way, ew);
    check_eq("movetype", movetype, em);
    check_eq("spawn_pulse", spawn_pulse, m_pulse);
    check_eq("catch_cnt", catch_cnt, m_catch);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [NF-1:0] model_alive_vec();
    logic [NF-1:0] v;
    for (int i = 0; i < NF; i++) v[i] = m_alive[i];
    return v;
  endfunction

  task automatic wait_both_alive(input string tag);
    for (int n = 0; n < 40 && model_alive_vec() != 2'b11; n++) cycle();
    check_eq(tag, appear, 2'b11);
  endtask

  initial begin
    logic [1:0] w;
    logic [2:0] mt;
    m_catch_total = 0;
    rst = 1'b1; game_en = 1'b0; tick = 1'b0; caught = '0; offscreen = '0;
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    check_eq("rst_appear", appear, 0);
    check_eq("rst_catch", catch_cnt, 0);
    check_eq("rst_pulse", spawn_pulse, 0);

    // First spawns: slot 0 on edge 4, slot 1 on edge 8
    rst = 1'b0; game_en = 1'b1; tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k < 4) check_eq("pre_spawn_appear", appear, 2'b00);
      if (k == 4) begin
        check_eq("spawn0_appear", appear, 2'b01);
        check_eq("spawn0_pulse", spawn_pulse, 1);
        w = way[1:0]; mt = movetype[2:0];
        check_eq("spawn0_way", w, 0);
        check_eq("spawn0_mt", mt, 0);
      end
      if (k > 4 && k < 8) check_eq("gap_pulse", spawn_pulse, 0);
      if (k == 8) begin
        check_eq("spawn1_appear", appear, 2'b11);
        w = way[3:2]; mt = movetype[5:3];
        check_eq("spawn1_way", w, 1);
        check_eq("spawn1_mt", mt, 1);
      end
    end

    // Pool full: pending holds, then a catch frees slot 0
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_eq("full_no_spawn", spawn_pulse, 0);
    end
    caught = 2'b01;
    cycle();
    caught = '0;
    check_eq("catch_appear", appear, 2'b10);
    check_eq("catch_cnt1", catch_cnt, 1);
    cycle();
    check_eq("cool_appear_a", appear, 2'b10);
    cycle();
    check_eq("cool_appear_b", appear, 2'b10);
    cycle();
    check_eq("respawn_appear", appear, 2'b11);
    check_eq("respawn_pulse", spawn_pulse, 1);
    w = way[1:0]; mt = movetype[2:0];
    check_eq("respawn_way", w, 2);
    check_eq("respawn_mt", mt, 2);

    // Caught and offscreen together count once
    caught = 2'b10; offscreen = 2'b10;
    cycle();
    caught = '0; offscreen = '0;
    check_eq("both_catch_cnt", catch_cnt, 2);
    check_eq("both_appear", appear, 2'b01);

    // Saturation: catch every fish as soon as it appears
    for (int n = 0; n < 6000 && m_catch_total < 262; n++) begin
      caught = model_alive_vec();
      cycle();
    end
    caught = '0;
    check_eq("catch_saturated", catch_cnt, 255);

    // Disable with slot 0 active and slot 1 cooling
    wait_both_alive("wait_both_a");
    offscreen = 2'b10;
    cycle();
    offscreen = '0;
    check_eq("off_appear", appear, 2'b01);
    game_en = 1'b0;
    cycle();
    check_eq("disable_appear", appear, 2'b00);
    for (int k = 0; k < 5; k++) begin
      caught = 2'($urandom); offscreen = 2'($urandom);
      cycle();
      check_eq("disabled_pulse", spawn_pulse, 0);
      check_eq("disabled_appear", appear, 2'b00);
    end
    caught = '0; offscreen = '0;
    game_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      if (k < 4) check_eq("reen_idle", appear, 2'b00);
      else begin
        check_eq("reen_appear", appear, 2'b01);
        check_eq("reen_pulse", spawn_pulse, 1);
      end
    end

    // Reset while a spawn is pending
    wait_both_alive("wait_both_b");
    for (int k = 0; k < 8; k++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("midrst_appear", appear, 0);
    check_eq("midrst_way", way, 0);
    check_eq("midrst_mt", movetype, 0);
    check_eq("midrst_pulse", spawn_pulse, 0);
    check_eq("midrst_catch", catch_cnt, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      game_en   = ($urandom_range(0, 49) != 0);
      tick      = $urandom_range(0, 1) == 1;
      caught    = '0;
      offscreen = '0;
      for (int i = 0; i < NF; i++) begin
        caught[i]    = ($urandom_range(0, 9) == 0);
        offscreen[i] = ($urandom_range(0, 11) == 0);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fish_spawn_ctrl.md
# fish_spawn_ctrl

Spawn scheduler for the fishing-game playfield. It owns a fixed pool of fish slots and decides when each slot's fish appears. It assigns each spawned fish a direction and movement type, and retires the fish when it is caught or swims off screen. It sits between the movement timebase, which supplies `tick`, and the per-fish movement/render blocks, which consume `appear`, `way` and `movetype`. It also counts catches for the score display.

## Interface
- `NUM_FISH`, 4: number of fish slots, 1..8.
- `SPAWN_GAP`, 6: ticks between spawns, ≥1.
- `COOLDOWN_TICKS`, 3: ticks a slot stays empty after its fish leaves, ≥1.

- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous, active-high; one clock; reset is synchronous and active-high.
- `game_en`  in  1  level, game running.
- `tick`  in  1  one-cycle strobe from the movement timebase.
- `caught`  in  NUM_FISH  per-slot one-cycle pulse: the hook caught this fish.
- `offscreen`  in  NUM_FISH  per-slot level: this fish is outside the visible area.
- `appear`  out  NUM_FISH  per-slot level: 1 means the fish exists.
- `way`  out  2*NUM_FISH  per-slot direction: slot i uses bits [2i+1:2i]. 0 = left, 1 = right, 2 = up; 3 is never driven.
- `movetype`  out  3*NUM_FISH  per-slot motion pattern: slot i uses bits [3i+2:3i].
- `spawn_pulse`  out  1  high for one cycle on every spawn.
- `catch_cnt`  out  8  total fish caught, saturating.

## Operation
- Each slot has its own FSM:
  - IDLE: `appear`=0.
  - ACTIVE: `appear`=1.
  - COOLDOWN: `appear`=0; a tick down-counter is loaded with COOLDOWN_TICKS on entry.
- Transitions:
  - ACTIVE→COOLDOWN when `caught[i]` is high, or when `offscreen[i]` is high.
  - COOLDOWN→IDLE on the tick that decrements the counter from 1 to 0.
- A `caught[i]` pulse in ACTIVE increments `catch_cnt`; the count saturates at 255.
- If `caught[i]` and `offscreen[i]` are high in the same cycle, it counts as a catch.
- `caught`/`offscreen` on a slot that is not ACTIVE are ignored.
- Spawn timer: 0..SPAWN_GAP-1. It increments on each `tick` while no spawn is pending.
- On a tick with timer==SPAWN_GAP-1:
  - If any slot is IDLE (registered state), the lowest-index IDLE slot goes ACTIVE and the timer goes to 0.
  - Otherwise `pending` is set and the timer holds.
- While `pending`=1, the spawn fires on the first clock (tick not required) in which an IDLE slot exists. `pending` then clears and the timer resets to 0.
- A slot that leaves COOLDOWN in a given cycle is spawnable from the next cycle.
- On spawn, the slot's `way`/`movetype` are latched and held until its next spawn. Their value is set by the Configuration section.
- 16-bit spawn counter `spawn_cnt` increments on each spawn and wraps.
- When `game_en`=0:
  - All slots go IDLE at the next edge.
  - The spawn timer, `pending` and the cooldown counters clear.
  - `catch_cnt` and `spawn_cnt` hold.
  - Inputs are ignored.

## Timing
- Reset values: `appear`=0, `way`=0, `movetype`=0, `spawn_pulse`=0, `catch_cnt`=0; timer, `pending` and `spawn_cnt` are 0; all slots IDLE.
- All outputs are registered; there is no combinational input-to-output path.
- Spawn latency: `appear[i]` and `spawn_pulse` go high on the edge that samples the triggering tick (or the pending-resolving cycle).
- Retire latency: `appear[i]` falls one edge after `caught`/`offscreen` is sampled; `catch_cnt` updates on the same edge.
- Reset asserted mid-operation overrides everything at the next edge.
- At most one spawn per cycle.

## Configuration
- `FISH_SPAWN_RANDOM_EN` defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every clock.
  - On spawn: `way` = lfsr[1:0], with 3 mapped to 0; `movetype` = lfsr[4:2].
- `FISH_SPAWN_RANDOM_EN` undefined:
  - No LFSR is built.
  - On spawn: `way` = spawn_cnt mod 3; `movetype` = spawn_cnt[2:0], using the value before the increment.

## Test plan
Common setup: NUM_FISH=2, SPAWN_GAP=4, COOLDOWN_TICKS=2, `tick`=1 every cycle, macro undefined.

- Reset, then `game_en`=1 → `appear`=00 for 3 edges. On the 4th edge `appear[0]`=1, `spawn_pulse`=1 for one cycle, `way[1:0]`=0, `movetype[2:0]`=0. On the 8th edge `appear[1]`=1, `way[3:2]`=1, `movetype[5:3]`=1.
- Both slots ACTIVE, wait past the gap → no spawn and pending holds. Pulse `caught[0]` → `appear[0]`=0 and `catch_cnt`=1 next edge. After 2 ticks slot 0 is IDLE; it respawns on the following edge.
- `caught[1]` and `offscreen[1]` in the same cycle on an ACTIVE slot → `catch_cnt` +1 once, `appear[1]`=0.
- 256 catches → `catch_cnt` stays 255.
- `game_en`=0 while slot 0 ACTIVE and slot 1 in COOLDOWN → both IDLE next edge, no spawn while low. Re-enable → first spawn 4 ticks later, into slot 0.
- `rst` pulsed mid-pending → all outputs 0 next edge; with the macro defined, the LFSR sequence restarts from 16'hACE1.
